cache_read_scheduler: RTL

Per-frame read scheduler between the per-sensor cache FIFOs (`cache_wrapper`) and the message/SRIO framing path. On each frame-start pulse it snapshots every channel's FIFO fill level. It then serves the non-empty channels once each, in rotating round-robin order, issuing length-bounded byte bursts tagged with channel ID, start-of-burst and end-of-burst markers. It honours downstream `prog_full` back-pressure and flags frame overruns and FIFO underruns.

---
 rtl/kg_sched_pkg.sv | 6 +
 rtl/cache_read_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/kg_sched_pkg.sv
// rtl/kg_sched_pkg.sv - shared state encoding and constants for the cache read scheduler
package kg_sched_pkg;
    typedef enum logic [2:0] {IDLE, ARB, READ, DRAIN, DONE} state_t;
    localparam int CH_ID_W      = 8;
    localparam int DRAIN_CYCLES = 2;
endpackage

// File: rtl/cache_read_scheduler.sv
// rtl/cache_read_scheduler.sv - per-frame round-robin burst reader over the per-sensor cache FIFOs
module cache_read_scheduler
    import kg_sched_pkg::*;
#(
    parameter int SENSOR_NUM = 1,
    parameter int MAX_BURST  = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_i,
    input  logic                        frame_start_pluse_i,
    input  logic [SENSOR_NUM-1:0]       empty_i,
    input  logic [SENSOR_NUM*CNT_W-1:0] data_count_i,
    input  logic [SENSOR_NUM*8-1:0]     din_i,
    output logic [SENSOR_NUM-1:0]       rd_en_o,
    input  logic                        prog_full_i,
    output logic [7:0]                  dout_o,
    output logic                        dout_valid_o,
    output logic                        sob_o,
    output logic                        eob_o,
    output logic [CH_ID_W-1:0]          ch_id_o,
    output logic                        busy_o,
    output logic                        frame_overrun_o,
    output logic                        underrun_o,
    output logic [7:0]                  overrun_cnt_o
);
    localparam int                CUR_W     = (SENSOR_NUM > 1) ? $clog2(SENSOR_NUM) : 1;
    localparam int                DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CUR_W-1:0]  LAST_CH   = CUR_W'(SENSOR_NUM - 1);
    localparam logic [CNT_W-1:0]  BURST_CAP = CNT_W'(MAX_BURST);

    function automatic logic [CUR_W-1:0] next_ch(input logic [CUR_W-1:0] c);
        return (c == LAST_CH) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v > BURST_CAP) ? BURST_CAP : v;
    endfunction

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       snap [SENSOR_NUM];
    logic [SENSOR_NUM-1:0]  visited;
    logic [CUR_W-1:0]       cur, start_ptr;
    logic [CNT_W-1:0]       remaining;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   first_pend;
    logic                   rd_d1, sob_d1;

    logic cur_empty, cur_eligible, rd_fire, drain_last, starved;

    assign cur_empty    = empty_i[cur];
    assign cur_eligible = (snap[cur] != '0) && !visited[cur];
    assign rd_fire      = (state == READ) && !prog_full_i && !cur_empty && (remaining != '0);
    assign starved      = (state == READ) && cur_empty && (remaining != '0);
    assign drain_last   = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        rd_en_o   = '0;
        case (state)
            IDLE:  if (frame_start_pluse_i) state_nxt = ARB;
            ARB: begin
                if (&visited)          state_nxt = DONE;
                else if (cur_eligible) state_nxt = READ;
            end
            READ: begin
                if (rd_fire) rd_en_o[cur] = 1'b1;
                if ((rd_fire && remaining == CNT_W'(1)) || starved) state_nxt = DRAIN;
            end
            DRAIN: if (drain_last) state_nxt = ARB;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SENSOR_NUM; k++) snap[k] <= '0;
            visited         <= '0;
            cur             <= '0;
            start_ptr       <= '0;
            remaining       <= '0;
            drain_cnt       <= '0;
            first_pend      <= 1'b0;
            ch_id_o         <= '0;
            busy_o          <= 1'b0;
            eob_o           <= 1'b0;
            underrun_o      <= 1'b0;
            frame_overrun_o <= 1'b0;
            overrun_cnt_o   <= '0;
        end else begin
            eob_o     <= 1'b0;
            drain_cnt <= '0;
            case (state)
                IDLE: begin
                    if (frame_start_pluse_i) begin
                        for (int k = 0; k < SENSOR_NUM; k++)
                            snap[k] <= clamp(data_count_i[k*CNT_W +: CNT_W]);
                        visited <= '0;
                        cur     <= start_ptr;
                        busy_o  <= 1'b1;
                    end
                end
                ARB: begin
                    if (!(&visited)) begin
                        if (cur_eligible) begin
                            remaining  <= snap[cur];
                            ch_id_o    <= CH_ID_W'(cur);
                            first_pend <= 1'b1;
                        end else begin
                            visited[cur] <= 1'b1;
                            cur          <= next_ch(cur);
                        end
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        remaining  <= remaining - CNT_W'(1);
                        first_pend <= 1'b0;
                    end
                    if (starved) underrun_o <= 1'b1;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    // eob lands one cycle after the last in-flight byte leaves the pipeline
                    if (drain_last) begin
                        eob_o        <= 1'b1;
                        visited[cur] <= 1'b1;
                        cur          <= next_ch(cur);
                    end
                end
                DONE: begin
                    start_ptr <= next_ch(start_ptr);
                    busy_o    <= 1'b0;
                end
                default: ;
            endcase
            if (frame_start_pluse_i && busy_o) begin
                frame_overrun_o <= 1'b1;
                if (overrun_cnt_o != 8'hFF) overrun_cnt_o <= overrun_cnt_o + 8'd1;
            end
        end
    end

    // Fixed two-stage byte path: FIFO read latency plus the output register.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_d1        <= 1'b0;
            sob_d1       <= 1'b0;
            dout_valid_o <= 1'b0;
            sob_o        <= 1'b0;
            dout_o       <= '0;
        end else begin
            rd_d1        <= rd_fire;
            sob_d1       <= rd_fire && first_pend;
            dout_valid_o <= rd_d1;
            sob_o        <= sob_d1;
            if (rd_d1) dout_o <= din_i[int'(cur)*8 +: 8];
        end
    end
endmodule
